c17_bist_ctrl: RTL
==================

# c17_bist_ctrl

Built-in self-test controller for the c17 benchmark core. It generates pseudo-random input patterns with a 5-bit LFSR and drives them onto the c17 primary inputs. It captures the two c17 outputs each pattern into an 8-bit MISR and compares the final signature against a golden value. It replaces file-driven stimulus and gold dumps with an on-chip pattern source and response analyzer, sitting between the test-control port and the c17 instance.

## Interface
- `N_PATTERNS`, default 31: patterns applied per run; range 0..255.
- `LFSR_SEED`, default 5'b00001: initial LFSR state. A zero seed is replaced by 5'b00001.
- `GOLDEN_SIG`, default 8'h00: expected MISR signature, taken from golden simulation.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; begins a run when in IDLE or DONE.
- `tpg_out`  out  5: pattern bits to c17, mapped {N7,N6,N3,N2,N1} = tpg_out[4:0].
- `resp_in`  in  2: c17 response {N23,N22}.
- `busy`  out  1: high from the cycle after accepted `start` until DONE is entered.
- `done`  out  1: high in DONE state.
- `pass`  out  1: valid when `done`; 1 iff signature == GOLDEN_SIG.
- `signature`  out  8: current MISR contents.
- `pattern_cnt`  out  8: patterns captured so far in the current run.

## Operation
- States:
  - IDLE: on `start`, go to APPLY.
  - APPLY: on the next cycle, go to CAPTURE.
  - CAPTURE: if `pattern_cnt`+1 == N_PATTERNS, go to COMPARE; otherwise go to APPLY.
  - COMPARE: go to DONE.
  - DONE: on `start`, go to APPLY.
  - N_PATTERNS==0: IDLE or DONE on `start` goes directly to COMPARE.
- Run initialisation (on accepted `start`): LFSR = seed, MISR = 8'h00, `pattern_cnt` = 0, `done` = 0, `pass` = 0.
- APPLY: `tpg_out` = LFSR state and is held stable. c17 is combinational, so `resp_in` settles within this cycle.
- CAPTURE, in one edge:
  - MISR update: fb = m[7]; m_next = {m[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00) ^ {6'b0, resp_in}. This is polynomial x^8+x^4+x^3+x^2+1.
  - LFSR advance: q_next = {q[3:0], q[4]^q[2]}. This is x^5+x^3+1, maximal length with period 31.
  - `pattern_cnt` increments.
- COMPARE: registers `pass` = (MISR == GOLDEN_SIG).
- DONE: `done` = 1. `signature` and `pass` are held until the next `start` or `rst`.
- `start` while `busy` is ignored.
- `tpg_out` outside APPLY/CAPTURE holds the last driven value (the seed after reset).

## Timing
- Reset values:
  - state IDLE
  - `tpg_out` = sanitised LFSR_SEED
  - `busy` = 0, `done` = 0, `pass` = 0
  - `signature` = 8'h00, `pattern_cnt` = 0
- Run length: with `start` sampled at edge 0, `done` rises at edge 2·N_PATTERNS+2. For N_PATTERNS==0 it rises at edge 2.
- Each pattern occupies exactly 2 cycles (APPLY, CAPTURE). `resp_in` is sampled only at the CAPTURE edge.
- `rst` mid-run: aborts at the next edge to the full reset state. No partial signature or `done` is retained.
- `start` and `rst` in the same cycle: `rst` wins.
- LFSR sequence from seed 5'h01: 01, 02, 04, 09, 12, …; it returns to 01 after 31 steps.

## Structure
- Shared package `c17_bist_pkg` holds:
  - state enum (IDLE, APPLY, CAPTURE, COMPARE, DONE)
  - MISR polynomial constant 8'h1D
  - LFSR tap positions
  - `c17_pin_map` constants for the {N7,N6,N3,N2,N1} / {N23,N22} ordering
- One natural sub-module: `bist_misr`, an 8-bit MISR with clear and enable.
- The LFSR and FSM stay inline.

## Test plan
- Reset then idle: `tpg_out`=5'h01, `signature`=8'h00, and `busy`, `done`, `pass` are all 0. `start` is pulsed with `rst` high, and the block stays IDLE.
- N_PATTERNS=5, `resp_in` tied 2'b00, GOLDEN_SIG=8'h00:
  - `tpg_out` across APPLY cycles = 01, 02, 04, 09, 12
  - `done` at edge 12, `signature`=8'h00, `pass`=1
- N_PATTERNS=2, `resp_in` tied 2'b01, GOLDEN_SIG=8'h03:
  - `signature` goes 01 then 03, `pass`=1
  - Same run with GOLDEN_SIG=8'h04 gives `pass`=0
- Real c17 attached, N_PATTERNS=31: `signature` equals the bench reference model's MISR over the NAND-level c17 responses. An injected stuck-at-0 on N22 gives `pass`=0.
- Abort and edge cases:
  - `rst` asserted at pattern 3 of 31 gives the reset state next cycle.
  - A following `start` completes normally.
  - `start` pulsed while `busy` has no effect on `pattern_cnt`.
- N_PATTERNS=0: `done` at edge 2, `signature`=8'h00, `pass`=(GOLDEN_SIG==8'h00). A second `start` from DONE reruns with the same result.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST controller: FSM states, LFSR/MISR
// polynomials and the bit ordering of the c17 pins on the pattern/response buses.
package c17_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } bist_state_t;

  localparam logic [7:0] MISR_POLY   = 8'h1D;
  localparam int         LFSR_TAP_HI = 4;
  localparam int         LFSR_TAP_LO = 2;

  // c17_pin_map: tpg_out = {N7,N6,N3,N2,N1}, resp_in = {N23,N22}
  localparam int C17_PIN_N1  = 0;
  localparam int C17_PIN_N2  = 1;
  localparam int C17_PIN_N3  = 2;
  localparam int C17_PIN_N6  = 3;
  localparam int C17_PIN_N7  = 4;
  localparam int C17_PIN_N22 = 0;
  localparam int C17_PIN_N23 = 1;

  function automatic logic [4:0] lfsr_next(input logic [4:0] q);
    return {q[3:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  function automatic logic [4:0] sanitise_seed(input logic [4:0] s);
    return (s == 5'd0) ? 5'd1 : s;
  endfunction

endpackage

// File: rtl/c17_bist_ctrl_misr.sv
// 8-bit multiple-input signature register (x^8+x^4+x^3+x^2+1) folding in the
// two c17 response bits on each enabled cycle.
module bist_misr
  import c17_bist_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [1:0] i_din,
  output logic [7:0] o_sig
);

  logic [7:0] r_sig;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sig <= 8'h00;
    end else if (i_en) begin
      r_sig <= {r_sig[6:0], 1'b0} ^ (r_sig[7] ? MISR_POLY : 8'h00) ^ {6'b0, i_din};
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for c17: LFSR pattern source, MISR response compaction and a
// final compare against a golden signature.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int         N_PATTERNS = 31,
  parameter logic [4:0] LFSR_SEED  = 5'b00001,
  parameter logic [7:0] GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] tpg_out,
  input  logic [1:0] resp_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] pattern_cnt
);

  localparam logic [4:0] SEED  = sanitise_seed(LFSR_SEED);
  localparam logic [8:0] N_PAT = 9'(N_PATTERNS);

  bist_state_t r_state;
  bist_state_t w_state_next;
  logic        r_launch;
  logic [4:0]  r_lfsr;
  logic [7:0]  r_cnt;
  logic        r_pass;
  logic [7:0]  w_sig;
  logic [1:0]  w_resp;
  logic        w_busy;
  logic        w_accept;
  logic        w_capture;
  logic        w_last;

  // r_launch marks the cycle between an accepted start and the first APPLY;
  // the run counts as busy from then on.
  assign w_busy    = r_launch || (r_state inside {S_APPLY, S_CAPTURE, S_COMPARE});
  assign w_accept  = start && !w_busy;
  assign w_capture = (r_state == S_CAPTURE);
  assign w_last    = ({1'b0, r_cnt} + 9'd1) == N_PAT;
  assign w_resp    = {resp_in[C17_PIN_N23], resp_in[C17_PIN_N22]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_launch) w_state_next = (N_PATTERNS == 0) ? S_COMPARE : S_APPLY;
      end
      S_APPLY:   w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = w_last ? S_COMPARE : S_APPLY;
      S_COMPARE: w_state_next = S_DONE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_launch <= 1'b0;
      r_lfsr   <= SEED;
      r_cnt    <= 8'd0;
      r_pass   <= 1'b0;
    end else begin
      r_launch <= w_accept;
      if (w_accept) begin
        r_cnt  <= 8'd0;
        r_pass <= 1'b0;
      end else if (w_capture) begin
        r_cnt <= r_cnt + 8'd1;
        // Holding the last pattern keeps tpg_out at the final driven value.
        if (!w_last) r_lfsr <= lfsr_next(r_lfsr);
      end else if (r_state == S_COMPARE) begin
        r_pass <= (w_sig == GOLDEN_SIG);
      end
      if (r_launch) r_lfsr <= SEED;
    end
  end

  bist_misr u_misr (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_accept),
    .i_en  (w_capture),
    .i_din (w_resp),
    .o_sig (w_sig)
  );

  assign tpg_out     = r_lfsr;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE) && !r_launch;
  assign pass        = r_pass;
  assign signature   = w_sig;
  assign pattern_cnt = r_cnt;

endmodule
